// File: rtl/fpg8_pkg.sv
// Shared definitions for the alu_z datapath: width, opcodes, flag bit positions.
package fpg8_pkg;

  localparam int W = 16;

  localparam int FLAG_N  = 3;
  localparam int FLAG_ZF = 2;
  localparam int FLAG_C  = 1;
  localparam int FLAG_V  = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_PASS = 4'd6,
    OP_INC  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_ASR  = 4'd10,
    OP_MUL  = 4'd11
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } alu_state_e;

  function automatic logic [3:0] mk_flags(input logic [W-1:0] z, input logic c, input logic v);
    logic [3:0] f;
    f          = '0;
    f[FLAG_N]  = z[W-1];
    f[FLAG_ZF] = (z == '0);
    f[FLAG_C]  = c;
    f[FLAG_V]  = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_z_if.sv
// Control/status bundle between the CPU sequencer (master) and alu_z (slave).
interface alu_z_if;
  import fpg8_pkg::*;

  logic [W-1:0] REG_IN_Y;
  logic [3:0]   ALU_op;
  logic         ALU_start;
  logic         Z_out;
  logic [W-1:0] REG_OUT_Z;
  logic [3:0]   FLAGS;
  logic         busy;
  logic         done;

  modport slave (
    input  REG_IN_Y, ALU_op, ALU_start, Z_out,
    output REG_OUT_Z, FLAGS, busy, done
  );

  modport master (
    output REG_IN_Y, ALU_op, ALU_start, Z_out,
    input  REG_OUT_Z, FLAGS, busy, done
  );
endinterface

// File: rtl/alu_comb.sv
// Combinational result and flags for the single-cycle opcodes (ADD..INC).
module alu_comb
  import fpg8_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [3:0]   i_op,
  output logic [W-1:0] o_y,
  output logic [3:0]   o_flags
);

  logic [W:0] w_sum;
  logic       w_c;
  logic       w_v;

  always_comb begin
    w_sum = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    o_y   = '0;
    case (i_op)
      OP_ADD: begin
        w_sum = {1'b0, i_a} + {1'b0, i_b};
        o_y   = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (i_a[W-1] == i_b[W-1]) && (o_y[W-1] != i_a[W-1]);
      end
      OP_SUB: begin
        o_y = i_a - i_b;
        w_c = (i_a < i_b);
        w_v = (i_a[W-1] != i_b[W-1]) && (o_y[W-1] != i_a[W-1]);
      end
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_NOT:  o_y = ~i_b;
      OP_PASS: o_y = i_b;
      OP_INC: begin
        w_sum = {1'b0, i_b} + {{W{1'b0}}, 1'b1};
        o_y   = w_sum[W-1:0];
        w_c   = w_sum[W];
        // Only 0x7FFF+1 crosses the signed boundary.
        w_v   = !i_b[W-1] && o_y[W-1];
      end
      default: ;
    endcase
    o_flags = mk_flags(o_y, w_c, w_v);
  end

endmodule

// File: rtl/alu_z.sv
// ALU with result register Z, iterative shift/MUL sequencer and tristate bus drive.
// Define ALU_MUL_EN to build the 16-cycle shift-add multiplier for opcode 11.
module alu_z
  import fpg8_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  inout  wire [W-1:0]  DATA,
  alu_z_if.slave       bus
);

  alu_state_e   r_state, w_state_next;
  logic [4:0]   r_cnt, w_cnt_next;
  logic [W-1:0] r_acc, w_acc_next;
  logic [W-1:0] r_z, w_z_next;
  logic [3:0]   r_flags, w_flags_next;
  logic [3:0]   r_op, w_op_next;
  logic         r_done, w_done_next;

  logic [W-1:0] w_a, w_b, w_comb_y, w_step_val;
  logic [3:0]   w_comb_flags;
  logic         w_step_c, w_is_shift;

  assign w_a = bus.REG_IN_Y;
  assign w_b = DATA;
  assign w_is_shift = (bus.ALU_op == OP_SHL) || (bus.ALU_op == OP_SHR) || (bus.ALU_op == OP_ASR);

  alu_comb u_comb (
    .i_a     (w_a),
    .i_b     (w_b),
    .i_op    (bus.ALU_op),
    .o_y     (w_comb_y),
    .o_flags (w_comb_flags)
  );

  always_comb begin
    w_step_val = {r_acc[W-1], r_acc[W-1:1]};
    w_step_c   = r_acc[0];
    if (r_op == OP_SHL) begin
      w_step_val = {r_acc[W-2:0], 1'b0};
      w_step_c   = r_acc[W-1];
    end else if (r_op == OP_SHR) begin
      w_step_val = {1'b0, r_acc[W-1:1]};
    end
  end

`ifdef ALU_MUL_EN
  // Product lives in {r_hi, r_acc}; r_acc starts as the multiplier and drains LSB-first.
  logic [W-1:0] r_hi, w_hi_next, r_mcand, w_mcand_next;
  logic [W:0]   w_mul_sum;
  logic [W-1:0] w_mul_hi, w_mul_lo;

  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_mul_hi  = w_mul_sum[W:1];
    w_mul_lo  = {w_mul_sum[0], r_acc[W-1:1]};
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_acc_next   = r_acc;
    w_z_next     = r_z;
    w_flags_next = r_flags;
    w_op_next    = r_op;
    w_done_next  = 1'b0;
`ifdef ALU_MUL_EN
    w_hi_next    = r_hi;
    w_mcand_next = r_mcand;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.ALU_start) begin
          if (bus.ALU_op <= OP_INC) begin
            w_z_next     = w_comb_y;
            w_flags_next = w_comb_flags;
            w_done_next  = 1'b1;
          end else if (w_is_shift) begin
            if (w_b[3:0] == 4'd0) begin
              w_z_next     = w_a;
              w_flags_next = mk_flags(w_a, 1'b0, 1'b0);
              w_done_next  = 1'b1;
            end else begin
              w_acc_next   = w_a;
              w_cnt_next   = {1'b0, w_b[3:0]};
              w_op_next    = bus.ALU_op;
              w_state_next = ST_RUN;
            end
          end
`ifdef ALU_MUL_EN
          else if (bus.ALU_op == OP_MUL) begin
            w_acc_next   = w_b;
            w_hi_next    = '0;
            w_mcand_next = w_a;
            w_cnt_next   = 5'd16;
            w_op_next    = bus.ALU_op;
            w_state_next = ST_RUN;
          end
`endif
        end
      end
      ST_RUN: begin
        w_cnt_next = r_cnt - 5'd1;
        w_acc_next = w_step_val;
`ifdef ALU_MUL_EN
        if (r_op == OP_MUL) begin
          w_acc_next = w_mul_lo;
          w_hi_next  = w_mul_hi;
        end
`endif
        if (r_cnt == 5'd1) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
          w_z_next     = w_step_val;
          w_flags_next = mk_flags(w_step_val, w_step_c, 1'b0);
`ifdef ALU_MUL_EN
          if (r_op == OP_MUL) begin
            w_z_next     = w_mul_lo;
            w_flags_next = mk_flags(w_mul_lo, |w_mul_hi, 1'b0);
          end
`endif
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_z     <= '0;
      r_flags <= '0;
      r_op    <= '0;
      r_done  <= 1'b0;
`ifdef ALU_MUL_EN
      r_hi    <= '0;
      r_mcand <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_acc   <= w_acc_next;
      r_z     <= w_z_next;
      r_flags <= w_flags_next;
      r_op    <= w_op_next;
      r_done  <= w_done_next;
`ifdef ALU_MUL_EN
      r_hi    <= w_hi_next;
      r_mcand <= w_mcand_next;
`endif
    end
  end

  assign DATA          = bus.Z_out ? r_z : {W{1'bz}};
  assign bus.REG_OUT_Z = r_z;
  assign bus.FLAGS     = r_flags;
  assign bus.busy      = (r_state == ST_RUN);
  assign bus.done      = r_done;

endmodule

// File: tb/tb_alu_z.sv
// Bench for alu_z: directed vector table, multi-cycle corner sequences, random ops vs model.
module tb_alu_z;
  import fpg8_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  wire  [15:0] DATA;
  logic [15:0] drv_val = 16'h0;
  logic        drv_en = 1'b1;

  alu_z_if bus_if ();

  assign DATA = drv_en ? drv_val : 16'bz;

  alu_z dut (
    .clk   (clk),
    .reset (reset),
    .DATA  (DATA),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] m_z = 16'h0;
  logic [3:0]  m_f = 4'h0;

  typedef struct {
    int          op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] z;
    logic [3:0]  f;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the opcode rules; lat=-1 reserved, 0 single cycle, n busy cycles.
  function automatic void model(input int op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] z, output logic [3:0] f, output int lat);
    int ua, ub, sa, sb, r, n;
    longint p;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    n = int'(b[3:0]);
    c = 1'b0; v = 1'b0; r = 0; lat = 0;
    case (op)
      0: begin r = ua + ub; c = (r > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
      1: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 32767) || (sa - sb < -32768); end
      2: r = ua & ub;
      3: r = ua | ub;
      4: r = ua ^ ub;
      5: r = ~ub;
      6: r = ub;
      7: begin r = ub + 1; c = (r > 65535); v = (sb + 1 > 32767); end
      8: begin r = ua << n; c = (n != 0) && (((ua << n) >> 16) & 1) == 1; lat = n; end
      9: begin r = ua >> n; c = (n != 0) && ((ua >> (n - 1)) & 1) == 1; lat = n; end
      10: begin r = sa >>> n; c = (n != 0) && ((sa >>> (n - 1)) & 1) == 1; lat = n; end
`ifdef ALU_MUL_EN
      11: begin p = longint'(ua) * longint'(ub); r = int'(p & 64'hFFFF); c = (p >> 16) != 0; lat = 16; end
`endif
      default: lat = -1;
    endcase
    if (lat < 0) begin
      z = m_z; f = m_f;
    end else begin
      z = r[15:0];
      f = {z[15], (z == 16'h0), c, v};
    end
  endfunction

  // zfb: B taken from Z via Z_out; poke_at/rst_at: busy-cycle index for a stray start / a reset.
  task automatic do_op(input int op, input logic [15:0] a, input logic [15:0] b_in,
                       input bit zfb, input int poke_at, input int rst_at);
    logic [15:0] b, ez;
    logic [3:0]  ef;
    int lat;
    string nm;
    b = zfb ? m_z : b_in;
    model(op, a, b, ez, ef, lat);
    nm = $sformatf("op%0d", op);
    @(negedge clk);
    bus_if.REG_IN_Y = a;
    bus_if.ALU_op = 4'(op);
    if (zfb) begin drv_en = 1'b0; bus_if.Z_out = 1'b1; end
    else begin drv_en = 1'b1; drv_val = b; bus_if.Z_out = 1'b0; end
    bus_if.ALU_start = 1'b1;
    @(posedge clk); #1;
    bus_if.ALU_start = 1'b0;
    bus_if.Z_out = 1'b0;
    drv_en = 1'b1;
    if (lat < 0) begin
      chk({nm, "_rsv_busy"}, 32'(bus_if.busy), 32'd0);
      chk({nm, "_rsv_done"}, 32'(bus_if.done), 32'd0);
      chk({nm, "_rsv_z"}, 32'(bus_if.REG_OUT_Z), 32'(m_z));
      chk({nm, "_rsv_flags"}, 32'(bus_if.FLAGS), 32'(m_f));
      $display("op=%0d a=%h b=%h reserved Z=%h FLAGS=%b", op, a, b, bus_if.REG_OUT_Z, bus_if.FLAGS);
      return;
    end
    for (int i = 0; i < lat; i++) begin
      chk({nm, "_busy_hi"}, 32'(bus_if.busy), 32'd1);
      chk({nm, "_done_lo"}, 32'(bus_if.done), 32'd0);
      if (i == rst_at) begin
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        m_z = 16'h0; m_f = 4'h0;
        chk({nm, "_rst_z"}, 32'(bus_if.REG_OUT_Z), 32'd0);
        chk({nm, "_rst_flags"}, 32'(bus_if.FLAGS), 32'd0);
        chk({nm, "_rst_busy"}, 32'(bus_if.busy), 32'd0);
        chk({nm, "_rst_done"}, 32'(bus_if.done), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_rst_done2"}, 32'(bus_if.done), 32'd0);
        $display("op=%0d a=%h b=%h aborted by reset at busy cycle %0d", op, a, b, i + 1);
        return;
      end
      if (i == poke_at) begin
        @(negedge clk);
        bus_if.ALU_op = 4'd0;
        bus_if.ALU_start = 1'b1;
        @(posedge clk); #1;
        bus_if.ALU_start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk({nm, "_busy_lo"}, 32'(bus_if.busy), 32'd0);
    chk({nm, "_done_hi"}, 32'(bus_if.done), 32'd1);
    chk({nm, "_z"}, 32'(bus_if.REG_OUT_Z), 32'(ez));
    chk({nm, "_flags"}, 32'(bus_if.FLAGS), 32'(ef));
    m_z = ez; m_f = ef;
    $display("op=%0d a=%h b=%h lat=%0d -> Z=%h FLAGS=%b", op, a, b, lat, bus_if.REG_OUT_Z, bus_if.FLAGS);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, 32'(bus_if.done), 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{0,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001};
    vecs[1]  = '{1,  16'h0003, 16'h0005, 16'hFFFE, 4'b1010};
    vecs[2]  = '{2,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
    vecs[3]  = '{3,  16'h0000, 16'h0000, 16'h0000, 4'b0100};
    vecs[4]  = '{4,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100};
    vecs[5]  = '{5,  16'h1234, 16'h00FF, 16'hFF00, 4'b1000};
    vecs[6]  = '{6,  16'h0000, 16'h1234, 16'h1234, 4'b0000};
    vecs[7]  = '{7,  16'h0000, 16'hFFFF, 16'h0000, 4'b0110};
    vecs[8]  = '{0,  16'hFFFF, 16'h0001, 16'h0000, 4'b0110};
    vecs[9]  = '{1,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001};
    vecs[10] = '{7,  16'h0000, 16'h7FFF, 16'h8000, 4'b1001};
    vecs[11] = '{8,  16'h8001, 16'h0000, 16'h8001, 4'b1000};

    bus_if.REG_IN_Y = 16'h0;
    bus_if.ALU_op = 4'h0;
    bus_if.ALU_start = 1'b0;
    bus_if.Z_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_z", 32'(bus_if.REG_OUT_Z), 32'd0);
    chk("reset_flags", 32'(bus_if.FLAGS), 32'd0);
    chk("reset_busy", 32'(bus_if.busy), 32'd0);
    chk("reset_done", 32'(bus_if.done), 32'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, -1, -1);
      chk($sformatf("vec%0d_z", i), 32'(bus_if.REG_OUT_Z), 32'(vecs[i].z));
      chk($sformatf("vec%0d_flags", i), 32'(bus_if.FLAGS), 32'(vecs[i].f));
    end

    // SUB result on the bus via Z_out
    do_op(1, 16'h0003, 16'h0005, 1'b0, -1, -1);
    @(negedge clk); drv_en = 1'b0; bus_if.Z_out = 1'b1;
    #1;
    chk("zout_data", 32'(DATA), 32'h0000FFFE);
    bus_if.Z_out = 1'b0; drv_en = 1'b1;

    // ASR with a stray start during busy cycle 2
    do_op(10, 16'h8001, 16'h0004, 1'b0, 1, -1);
    chk("asr_z", 32'(bus_if.REG_OUT_Z), 32'h0000F800);
    chk("asr_flags", 32'(bus_if.FLAGS), 32'b1000);

    // MUL (or reserved when the multiplier is not built)
    do_op(6, 16'h0, 16'h00AB, 1'b0, -1, -1);
    do_op(11, 16'h0100, 16'h0101, 1'b0, -1, -1);
`ifdef ALU_MUL_EN
    chk("mul_z", 32'(bus_if.REG_OUT_Z), 32'h00000100);
    chk("mul_flags", 32'(bus_if.FLAGS), 32'b0010);
`else
    chk("mul_rsv_z", 32'(bus_if.REG_OUT_Z), 32'h000000AB);
`endif

    // Reset during busy cycle 5
`ifdef ALU_MUL_EN
    do_op(11, 16'h1234, 16'h5678, 1'b0, -1, 4);
`else
    do_op(8, 16'h1234, 16'h000F, 1'b0, -1, 4);
`endif
    chk("post_rst_z", 32'(bus_if.REG_OUT_Z), 32'd0);

    // Z feedback: INC of Z through the bus, then a reserved opcode
    do_op(6, 16'h0, 16'h0005, 1'b0, -1, -1);
    do_op(7, 16'h0, 16'h0, 1'b1, -1, -1);
    chk("zfb_z", 32'(bus_if.REG_OUT_Z), 32'h00000006);
    do_op(13, 16'h1111, 16'h2222, 1'b0, -1, -1);
    chk("rsv13_z", 32'(bus_if.REG_OUT_Z), 32'h00000006);

    for (int k = 0; k < 150; k++) begin
      do_op(int'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
